// File: rtl/alu_wb_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : alu_wb_pkg
//  Purpose  : Shared definitions for the ALU writeback stage: writeback FSM
//             state encoding and NZCV flag bit positions.
//  Contents : IDLE/WR_LO/WR_HI/DONE encodings, wb_state_t enum,
//             FLAG_N/FLAG_Z/FLAG_C/FLAG_V indices, FLAGS_W.
//  Revision : 1.0 - initial release
// ============================================================================
package alu_wb_pkg;

    // Writeback FSM encodings
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] WR_LO = 2'd1;
    localparam logic [1:0] WR_HI = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE  = IDLE,
        S_WR_LO = WR_LO,
        S_WR_HI = WR_HI,
        S_DONE  = DONE
    } wb_state_t;

    // Bit positions inside the {N,Z,C,V} flag vector
    localparam int FLAGS_W = 4;
    localparam int FLAG_N  = 3;
    localparam int FLAG_Z  = 2;
    localparam int FLAG_C  = 1;
    localparam int FLAG_V  = 0;

endpackage : alu_wb_pkg
`default_nettype wire

// File: rtl/wb_flag_next.sv
`default_nettype none
// ============================================================================
//  Module   : wb_flag_next
//  Purpose  : Combinational next-value of the NZCV flag register for the
//             writeback stage.
//  Ports    : long_op, flag_we, cond_ex  - operation qualifiers
//             Result, Result2            - ALU low/high results
//             ALUFlags                   - {N,Z,C,V} from the ALU
//             flags_cur                  - current flag register
//             flags_next                 - value to load on the capture edge
//  Revision : 1.0 - initial release
// ============================================================================
module wb_flag_next
    import alu_wb_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic               long_op,
    input  logic               flag_we,
    input  logic               cond_ex,
    input  logic [WIDTH-1:0]   Result,
    input  logic [WIDTH-1:0]   Result2,
    input  logic [FLAGS_W-1:0] ALUFlags,
    input  logic [FLAGS_W-1:0] flags_cur,
    output logic [FLAGS_W-1:0] flags_next
);

    logic w_prod_zero;

    // Long multiply: Z reflects the full 2*WIDTH product, not just one half
    assign w_prod_zero = (Result == '0) && (Result2 == '0);

    always_comb begin
        flags_next = flags_cur;
        if (cond_ex && flag_we) begin
            if (long_op) begin
                // C and V are architecturally unaffected by long multiplies
                flags_next[FLAG_N] = Result2[WIDTH-1];
                flags_next[FLAG_Z] = w_prod_zero;
            end else begin
                flags_next = ALUFlags;
            end
        end
    end

endmodule : wb_flag_next
`default_nettype wire

// File: rtl/alu_writeback.sv
`default_nettype none
// ============================================================================
//  Module   : alu_writeback
//  Purpose  : Writeback stage following the ALU in the multicycle ARM
//             datapath. Captures ALU results, owns the NZCV flag register
//             and sequences one (normal) or two (UMULL/SMULL: RdLo then
//             RdHi) writes through the single register-file write port.
//  Ports    : clk, reset (async, active-high)
//             wb_start, cond_ex, long_op, flag_we - controller handshake
//             Result, Result2, ALUFlags, rd_lo, rd_hi - ALU/decoder inputs
//             RegWrite, WA3, WD3                   - register-file write port
//             Flags                                - registered {N,Z,C,V}
//             busy, wb_done                        - status to controller
//  Revision : 1.0 - initial release
// ============================================================================
module alu_writeback
    import alu_wb_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int ADDR_W = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               wb_start,
    input  logic               cond_ex,
    input  logic               long_op,
    input  logic               flag_we,
    input  logic [WIDTH-1:0]   Result,
    input  logic [WIDTH-1:0]   Result2,
    input  logic [FLAGS_W-1:0] ALUFlags,
    input  logic [ADDR_W-1:0]  rd_lo,
    input  logic [ADDR_W-1:0]  rd_hi,
    output logic               RegWrite,
    output logic [ADDR_W-1:0]  WA3,
    output logic [WIDTH-1:0]   WD3,
    output logic [FLAGS_W-1:0] Flags,
    output logic               busy,
    output logic               wb_done
);

    wb_state_t          r_state;
    wb_state_t          w_state_next;

    logic [WIDTH-1:0]   r_lo_q;
    logic [WIDTH-1:0]   r_hi_q;
    logic [ADDR_W-1:0]  r_rd_lo_q;
    logic [ADDR_W-1:0]  r_rd_hi_q;
    logic               r_long_q;
    logic [FLAGS_W-1:0] r_flags;

    logic               w_accept;
    logic [FLAGS_W-1:0] w_flags_next;

    // A start is only honoured from IDLE; pulses while busy are dropped
    assign w_accept = (r_state == S_IDLE) && wb_start;

    wb_flag_next #(
        .WIDTH      (WIDTH)
    ) u_flag_next (
        .long_op    (long_op),
        .flag_we    (flag_we),
        .cond_ex    (cond_ex),
        .Result     (Result),
        .Result2    (Result2),
        .ALUFlags   (ALUFlags),
        .flags_cur  (r_flags),
        .flags_next (w_flags_next)
    );

    // ------------------------------------------------------------------
    // State and capture registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_lo_q    <= '0;
            r_hi_q    <= '0;
            r_rd_lo_q <= '0;
            r_rd_hi_q <= '0;
            r_long_q  <= 1'b0;
            r_flags   <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_accept && cond_ex) begin
                r_lo_q    <= Result;
                r_hi_q    <= Result2;
                r_rd_lo_q <= rd_lo;
                r_rd_hi_q <= rd_hi;
                r_long_q  <= long_op;
            end
            // Next-flag logic already holds the old value when squashed
            // or when the S bit is clear
            if (w_accept) begin
                r_flags <= w_flags_next;
            end
        end
    end

    // ------------------------------------------------------------------
    // Next-state and Moore outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        RegWrite     = 1'b0;
        WA3          = '0;
        WD3          = '0;
        wb_done      = 1'b0;
        busy         = (r_state != S_IDLE);

        case (r_state)
            S_IDLE: begin
                if (wb_start) begin
                    w_state_next = cond_ex ? S_WR_LO : S_DONE;
                end
            end
            S_WR_LO: begin
                RegWrite     = 1'b1;
                WA3          = r_rd_lo_q;
                WD3          = r_lo_q;
                w_state_next = r_long_q ? S_WR_HI : S_DONE;
            end
            S_WR_HI: begin
                RegWrite     = 1'b1;
                WA3          = r_rd_hi_q;
                WD3          = r_hi_q;
                w_state_next = S_DONE;
            end
            S_DONE: begin
                wb_done      = 1'b1;
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    assign Flags = r_flags;

endmodule : alu_writeback
`default_nettype wire
